// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - counter encodings, default entry layout and counter helper for the branch predictor
package bp_pkg;

  // 2-bit saturating direction counter states
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // Default geometry of the predictor table
  localparam int BP_PC_W      = 9;
  localparam int BP_BHT_DEPTH = 16;
  localparam int BP_IDX_W     = $clog2(BP_BHT_DEPTH);
  localparam int BP_TAG_W     = BP_PC_W - BP_IDX_W - 2;

  // One table entry at the default geometry
  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    ctr_e                ctr;
    logic [BP_PC_W-1:0]  target;
  } bp_entry_t;

  // Move the counter one step towards the observed outcome, holding at the ends
  function automatic ctr_e ctr_update(input ctr_e ctr, input logic taken);
    logic [1:0] c;
    ctr_e       res;
    c   = ctr;
    res = ctr;
    if (taken && (ctr != ST)) begin
      res = ctr_e'(c + 2'd1);
    end else if (!taken && (ctr != SNT)) begin
      res = ctr_e'(c - 2'd1);
    end
    return res;
  endfunction

endpackage

// File: rtl/bp_table.sv
// rtl/bp_table.sv - direct-mapped predictor storage: two async read ports, one sync write, sync clear
module bp_table
  import bp_pkg::*;
#(
  parameter int                DEPTH   = 16,
  parameter int                IDX_W   = 4,
  parameter int                DATA_W  = 16,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic [IDX_W-1:0]  ra_idx_i,
  output logic [DATA_W-1:0] ra_data_o,
  input  logic [IDX_W-1:0]  rb_idx_i,
  output logic [DATA_W-1:0] rb_data_o,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Reads see the stored value only; a same-cycle write lands after the edge
  assign ra_data_o = mem_q[ra_idx_i];
  assign rb_data_o = mem_q[rb_idx_i];

  // Clear every entry on reset, otherwise perform the single pending write
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= CLR_VAL;
      end
    end else if (we_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - fetch-side next-PC prediction plus EX-side resolve, redirect and training
module branch_predict_unit
  import bp_pkg::*;
#(
  parameter int PC_W      = BP_PC_W,
  parameter int BHT_DEPTH = BP_BHT_DEPTH,
  parameter int PERF_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   if_pc,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              ex_valid,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [31:0]       ex_imm,
  input  logic              ex_branch,
  input  logic              ex_jump,
  input  logic              ex_jalr,
  input  logic [31:0]       ex_alu_result,
  input  logic              ex_pred_taken,
  input  logic [31:0]       ex_pred_target,
  output logic [31:0]       pc_four,
  output logic              redirect,
  output logic [31:0]       redirect_pc,
  output logic [PERF_W-1:0] branch_count,
  output logic [PERF_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam int TAG_W = PC_W - IDX_W - 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    ctr_e             ctr;
    logic [PC_W-1:0]  target;
  } entry_t;

  localparam int     ENTRY_W   = $bits(entry_t);
  localparam entry_t CLR_ENTRY = '{valid: 1'b0, tag: '0, ctr: WNT, target: '0};

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  entry_t           if_entry, ex_entry, wr_entry;
  logic             wr_en;
  logic             if_hit, ex_hit;
  logic [PC_W-1:0]  if_pc4, ex_pc4, act_tgt, nxt;
  logic [31:0]      act_tgt_full;
  logic             act_taken, is_jal, is_cbr;
  logic [PERF_W-1:0] branch_count_q, branch_count_d;
  logic [PERF_W-1:0] mispredict_count_q, mispredict_count_d;
  logic             unused_hi;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[PC_W-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[PC_W-1:IDX_W+2];

  bp_table #(
    .DEPTH  (BHT_DEPTH),
    .IDX_W  (IDX_W),
    .DATA_W (ENTRY_W),
    .CLR_VAL(CLR_ENTRY)
  ) u_table (
    .clk_i    (clk),
    .resetn_i (reset),
    .ra_idx_i (if_idx),
    .ra_data_o(if_entry),
    .rb_idx_i (ex_idx),
    .rb_data_o(ex_entry),
    .we_i     (wr_en),
    .wr_idx_i (ex_idx),
    .wr_data_i(wr_entry)
  );

  // Fetch prediction; held not-taken while in reset
  assign if_hit      = if_entry.valid && (if_entry.tag == if_tag);
  assign if_pc4      = if_pc + PC_W'(4);
  assign pred_taken  = reset & if_hit & if_entry.ctr[1];
  assign pred_target = 32'(pred_taken ? if_entry.target : if_pc4);

  // Resolve the EX instruction and compare against what fetch assumed
  assign act_taken    = (ex_branch & ex_alu_result[0]) | ex_jump;
  assign act_tgt_full = ex_jalr ? {ex_alu_result[31:1], 1'b0} : (32'(ex_pc) + ex_imm);
  assign act_tgt      = act_tgt_full[PC_W-1:0];
  assign ex_pc4       = ex_pc + PC_W'(4);
  assign nxt          = act_taken ? act_tgt : ex_pc4;
  assign redirect     = ex_valid & reset &
                        ((act_taken != ex_pred_taken) |
                         (act_taken & (ex_pred_target[PC_W-1:0] != act_tgt)));
  assign redirect_pc  = 32'(nxt);
  assign pc_four      = 32'(ex_pc) + 32'd4;

  // Only the low PC_W bits of targets take part in prediction
  assign unused_hi = ^{act_tgt_full, ex_pred_target};

  assign is_jal = ex_jump & ~ex_jalr;
  assign is_cbr = ex_branch & ~ex_jump;
  assign ex_hit = ex_entry.valid && (ex_entry.tag == ex_tag);

  // Training write: jal forces strongly taken, branches step the counter, jalr never trains
  always_comb begin
    wr_en    = 1'b0;
    wr_entry = ex_entry;
    if (ex_valid) begin
      if (is_jal) begin
        wr_en           = 1'b1;
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = ex_tag;
        wr_entry.ctr    = ST;
        wr_entry.target = act_tgt;
      end else if (is_cbr) begin
        if (act_taken) begin
          wr_en           = 1'b1;
          wr_entry.valid  = 1'b1;
          wr_entry.tag    = ex_tag;
          wr_entry.ctr    = ctr_update(ex_entry.ctr, 1'b1);
          wr_entry.target = act_tgt;
        end else if (ex_hit) begin
          wr_en        = 1'b1;
          wr_entry.ctr = ctr_update(ex_entry.ctr, 1'b0);
        end
      end
    end
  end

  // Saturating next values of the performance counters
  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (ex_valid && (ex_branch || ex_jump) && !(&branch_count_q)) begin
      branch_count_d = branch_count_q + PERF_W'(1);
    end
    if (redirect && !(&mispredict_count_q)) begin
      mispredict_count_d = mispredict_count_q + PERF_W'(1);
    end
  end

  // Performance counter registers, cleared by reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the single-cycle branch resolver; adds dynamic prediction.
- Fetch side: a direct-mapped table of 2-bit saturating counters plus branch target entries gives a next-PC prediction.
- EX side: resolves branch/jump/jalr, detects mispredictions, issues the redirect/flush, trains the table and counts branches and mispredicts.

Parameters:
- PC_W, 9, PC width in bits; targets stored and compared on PC_W bits, zero-extended to 32 on outputs.
- BHT_DEPTH, 16, table entries; power of 2. IDX_W = log2(BHT_DEPTH). Requires PC_W >= IDX_W+3.
- PERF_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low
- if_pc  in  PC_W  fetch PC
- pred_taken  out  1  prediction for if_pc (combinational)
- pred_target  out  32  predicted next PC
- ex_valid  in  1  EX stage holds a valid instruction
- ex_pc  in  PC_W  PC of the EX instruction
- ex_imm  in  32  immediate
- ex_branch, ex_jump, ex_jalr  in  1 each  instruction class (jal = ex_jump & ~ex_jalr)
- ex_alu_result  in  32  bit0 = branch condition; holds rs1+imm for jalr
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction
- ex_pred_target  in  32  predicted target carried down the pipe
- pc_four  out  32  ex_pc+4
- redirect  out  1  mispredict: flush IF/ID, load redirect_pc
- redirect_pc  out  32  correct next PC
- branch_count  out  PERF_W  resolved control-flow instructions
- mispredict_count  out  PERF_W  redirects issued

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]. Entry holds {valid, tag, ctr[1:0], target[PC_W-1:0]}.
- Fetch read (combinational):
  - hit = valid & tag match.
  - pred_taken = hit & ctr[1].
  - pred_target = pred_taken ? target : if_pc+4, zero-extended to 32 bits.
- Resolve (combinational):
  - act_taken = (ex_branch & ex_alu_result[0]) | ex_jump.
  - act_tgt = ex_jalr ? {ex_alu_result[31:1],1'b0} : {zero-ext ex_pc}+ex_imm, truncated to PC_W bits.
  - nxt = act_taken ? act_tgt : ex_pc+4.
  - redirect = ex_valid & reset & (act_taken != ex_pred_taken | (act_taken & ex_pred_target[PC_W-1:0] != act_tgt)).
  - redirect_pc = nxt, zero-extended.
- Update, on the clock edge when ex_valid & reset:
  - Conditional branch: ctr saturating +1 if taken, -1 if not (00 and 11 hold). If taken, write tag and target and set valid. A not-taken miss does not allocate; its ctr is unchanged.
  - jal: write tag and target, set valid, ctr=11.
  - jalr: no table update; it always predicts through the miss path.
  - branch_count +1 when ex_valid & (ex_branch|ex_jump). mispredict_count +1 on redirect. Both saturate at all-ones.
- Same-cycle fetch read and EX write to the same index: the read returns the pre-write entry. There is no bypass.
- Reset (reset==0 at an edge):
  - All entries: valid=0, ctr=01 (weakly not-taken).
  - Both counters cleared to 0.
  - While reset is low: redirect=0 and pred_taken=0.
  - Reset wins over a simultaneous update.
  - Reset mid-operation discards all training; the first cycle after reset predicts not-taken everywhere.
- Latency: prediction and redirect are 0 cycles (combinational). Training is visible to fetch the cycle after the update edge.

Decomposition:
- Package bp_pkg holds:
  - ctr encodings SNT=00, WNT=01, WT=10, ST=11.
  - the entry struct typedef, parametrised by field widths via localparams.
  - a saturating counter-update function.
- One sub-module, bp_table: flop array with async read port, one synchronous write port, synchronous clear.
- Resolve logic and the performance counters stay in the top module.

Test Plan (PC_W=9, BHT_DEPTH=16):
1. Reset, then if_pc=0x040 -> pred_taken=0, pred_target=0x044; branch_count=0, mispredict_count=0.
2. Branch ex_pc=0x040, imm=0x20, alu[0]=1, ex_pred_taken=0 -> redirect=1, redirect_pc=0x060, mispredict_count=1. Next cycle if_pc=0x040 -> pred_taken=1 (ctr=10), pred_target=0x060.
3. Same branch with alu[0]=0, ex_pred_taken=1, ex_pred_target=0x060 -> redirect=1, redirect_pc=0x044. Fetch of 0x040 now predicts not-taken. Three consecutive takens -> ctr=11; a fourth taken keeps 11.
4. Aliasing: train 0x040 taken, then if_pc=0x140 (same index, different tag) -> pred_taken=0, pred_target=0x144.
5. jalr ex_pc=0x010, alu=0x0A5, ex_pred_taken=0 -> redirect=1, redirect_pc=0x0A4. if_pc=0x010 still misses. branch_count increments by 1.
6. Same-cycle write/read: if_pc=0x040 while the first taken update of 0x040 is written -> old miss returned. Assert reset low with ex_valid=1 -> redirect=0, entry not written, counters become 0.
